// File: rtl/sysbus_pkg.sv
// Shared definitions for the SysBus memory responder.
// Tag layout: [12] direction (READ=1 / WRITE=0), [11:8] request type,
// [7:0] initiator id. Also holds the responder state encoding.
package sysbus_pkg;

    localparam int TAG_W        = 13;
    localparam int TAG_DIR_BIT  = 12;
    localparam int TAG_TYPE_MSB = 11;
    localparam int TAG_TYPE_LSB = 8;

    localparam int BEATS = 8;

    localparam logic DIR_READ  = 1'b1;
    localparam logic DIR_WRITE = 1'b0;

    localparam logic [3:0] TYPE_MEMORY = 4'h1;
    localparam logic [3:0] TYPE_MMIO   = 4'h2;
    localparam logic [3:0] TYPE_PORT   = 4'h3;
    localparam logic [3:0] TYPE_IRQ    = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_RD_BURST = 2'd2,
        ST_WR_DATA  = 2'd3
    } state_e;

    function automatic logic tag_is_memory(input logic [TAG_W-1:0] tag);
        return tag[TAG_TYPE_MSB:TAG_TYPE_LSB] == TYPE_MEMORY;
    endfunction

    function automatic logic tag_is_read(input logic [TAG_W-1:0] tag);
        return tag[TAG_DIR_BIT] == DIR_READ;
    endfunction

endpackage

// File: rtl/sysbus_mem_array.sv
// Single-port word-addressed RAM backing the responder.
// Synchronous write, combinational read on the same address.
// Ports: clk, we (write enable), addr (word address), wdata, rdata.
// Contents are intentionally not reset.
module sysbus_mem_array #(
    parameter int WORDS = 4096,
    parameter int DW    = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// SysBus bottom-side responder: serves line-sized (8 x 64-bit) read and
// write requests from an internal memory. Non-memory request types follow
// the same handshake but read back zeros and drop write data.
// Ports: clk, reset (async, active-high); request side req/reqtag/reqcyc
// in, reqack out; response side resp/resptag/respcyc out, respack in.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | waiting for an address beat
// ST_RD_WAIT  | read accepted, latency down-counter running
// ST_RD_BURST | driving 8 read beats, advancing on respack
// ST_WR_DATA  | consuming 8 write data beats
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13,
    parameter int MEM_WORDS  = 4096,
    parameter int RD_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] req,
    input  logic [TAG_WIDTH-1:0]  reqtag,
    input  logic                  reqcyc,
    output logic                  reqack,
    output logic [DATA_WIDTH-1:0] resp,
    output logic [TAG_WIDTH-1:0]  resptag,
    output logic                  respcyc,
    input  logic                  respack
);

    localparam int ADDR_W = $clog2(MEM_WORDS);
    localparam int LINE_W = ADDR_W - 3;
    localparam int CNT_W  = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            beat_q, beat_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [DATA_WIDTH-1:0] resp_q, resp_d;
    logic                  respcyc_q, respcyc_d;

    logic [LINE_W-1:0]     req_line;
    logic                  cur_is_mem;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] rd_word;

    assign req_line = req[ADDR_W+2:6];

    sysbus_mem_array #(
        .WORDS (MEM_WORDS),
        .DW    (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (req),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            beat_q    <= '0;
            line_q    <= '0;
            tag_q     <= '0;
            resp_q    <= '0;
            respcyc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            line_q    <= line_d;
            tag_q     <= tag_d;
            resp_q    <= resp_d;
            respcyc_q <= respcyc_d;
        end
    end

    // Output / datapath steering. The RAM address always points at the word
    // that the next edge needs: the incoming line base in IDLE (latency-1
    // reads), word 0 while waiting, the following word during a burst.
    always_comb begin
        reqack   = reqcyc && (state_q == ST_IDLE || state_q == ST_WR_DATA) && !reset;
        mem_addr = {line_q, beat_q};
        case (state_q)
            ST_IDLE:     mem_addr = {req_line, 3'd0};
            ST_RD_WAIT:  mem_addr = {line_q, 3'd0};
            ST_RD_BURST: mem_addr = {line_q, beat_q + 3'd1};
            default:     mem_addr = {line_q, beat_q};
        endcase
        cur_is_mem = (state_q == ST_IDLE) ? tag_is_memory(reqtag) : tag_is_memory(tag_q);
        rd_word    = cur_is_mem ? mem_rdata : '0;
        mem_we     = (state_q == ST_WR_DATA) && reqack && tag_is_memory(tag_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        line_d    = line_q;
        tag_d     = tag_q;
        resp_d    = resp_q;
        respcyc_d = respcyc_q;
        case (state_q)
            ST_IDLE: begin
                if (reqack) begin
                    tag_d  = reqtag;
                    line_d = req_line;
                    beat_d = '0;
                    if (tag_is_read(reqtag)) begin
                        // Latency 1 means the first beat is presented right
                        // after the address edge, so skip the wait state.
                        if (RD_LATENCY == 1) begin
                            resp_d    = rd_word;
                            respcyc_d = 1'b1;
                            state_d   = ST_RD_BURST;
                        end else begin
                            cnt_d   = CNT_LOAD;
                            state_d = ST_RD_WAIT;
                        end
                    end else begin
                        state_d = ST_WR_DATA;
                    end
                end
            end
            ST_RD_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                // Fire on the edge where the counter reaches zero so the
                // first beat is valid RD_LATENCY-1 edges after acceptance.
                if (cnt_q == CNT_ONE) begin
                    resp_d    = rd_word;
                    respcyc_d = 1'b1;
                    beat_d    = '0;
                    state_d   = ST_RD_BURST;
                end
            end
            ST_RD_BURST: begin
                if (respack) begin
                    if (beat_q == 3'd7) begin
                        respcyc_d = 1'b0;
                        beat_d    = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                        resp_d = rd_word;
                    end
                end
            end
            ST_WR_DATA: begin
                if (reqack) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp    = resp_q;
    assign resptag = tag_q;
    assign respcyc = respcyc_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
module tb_sysbus_mem_responder;

    localparam int RD_LAT    = 4;
    localparam int MEMW      = 4096;
    localparam int NLINES    = MEMW / 8;

    typedef struct {
        logic [63:0] data;
        logic [12:0] tag;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        reqcyc;
    logic        reqack;
    logic [63:0] resp;
    logic [12:0] resptag;
    logic        respcyc;
    logic        respack;

    int tests_run;
    int tests_failed;

    exp_t        sb[$];
    logic [63:0] model[int];

    sysbus_mem_responder #(
        .DATA_WIDTH (64),
        .TAG_WIDTH  (13),
        .MEM_WORDS  (MEMW),
        .RD_LATENCY (RD_LAT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .reqtag  (reqtag),
        .reqcyc  (reqcyc),
        .reqack  (reqack),
        .resp    (resp),
        .resptag (resptag),
        .respcyc (respcyc),
        .respack (respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic int line_of(input logic [63:0] addr);
        return int'((addr >> 6) % NLINES);
    endfunction

    function automatic logic is_mem(input logic [12:0] tag);
        return tag[11:8] == 4'h1;
    endfunction

    task automatic push_expected(input logic [63:0] addr, input logic [12:0] tag);
        exp_t e;
        int   ln;
        ln = line_of(addr);
        for (int i = 0; i < 8; i++) begin
            e.tag  = tag;
            e.data = (is_mem(tag) && model.exists(ln * 8 + i)) ? model[ln * 8 + i] : 64'h0;
            sb.push_back(e);
        end
    endtask

    // Leaves reqcyc high after the last beat so a following request can be
    // offered in the very next cycle.
    task automatic write_line(input logic [63:0] addr, input logic [12:0] tag,
                              input logic [63:0] base, input int nbeats);
        int ln;
        ln = line_of(addr);
        @(negedge clk);
        req = addr; reqtag = tag; reqcyc = 1'b1;
        #1 check("wr_addr_ack", reqack, 1'b1);
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            req = base + 64'(i);
            #1 check("wr_beat_ack", reqack, 1'b1);
            if (is_mem(tag)) model[ln * 8 + i] = base + 64'(i);
        end
    endtask

    task automatic issue_read(input logic [63:0] addr, input logic [12:0] tag);
        @(negedge clk);
        req = addr; reqtag = tag; reqcyc = 1'b1; respack = 1'b0;
        #1 check("rd_addr_ack", reqack, 1'b1);
        push_expected(addr, tag);
        @(negedge clk);
        reqcyc = 1'b0;
    endtask

    // Called at the first falling edge after the address was accepted.
    task automatic collect_burst(input bit toggle, input bit busy);
        int          cyc;
        int          hi;
        int          got;
        bit          stalled;
        logic [63:0] held;
        exp_t        e;
        cyc = 1;
        #1;
        while (!respcyc && cyc < 64) begin
            if (busy) check("busy_wait_reqack", reqack, 1'b0);
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!respcyc) begin
            check("rd_timeout", respcyc, 1'b1);
            sb.delete();
            return;
        end
        check("rd_latency", 64'(cyc), 64'(RD_LAT));
        hi = 0; got = 0; stalled = 0; held = '0;
        while (got < 8 && hi < 40) begin
            respack = toggle ? ((hi % 2) == 0) : 1'b1;
            #1;
            check("burst_respcyc", respcyc, 1'b1);
            if (busy) check("busy_reqack", reqack, 1'b0);
            if (stalled) check("stall_hold", resp, held);
            if (respack) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("rd_data", resp, e.data);
                    check("rd_tag", 64'(resptag), 64'(e.tag));
                end
                got++;
                stalled = 0;
            end else begin
                held    = resp;
                stalled = 1;
            end
            hi++;
            @(negedge clk);
        end
        respack = 1'b0;
        #1;
        check("burst_len", 64'(hi), toggle ? 64'd15 : 64'd8);
        check("burst_end_respcyc", respcyc, 1'b0);
        if (busy) check("post_burst_reqack", reqack, 1'b1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b1;
        reqcyc  = 1'b1;
        req     = '0;
        reqtag  = '0;
        respack = 1'b0;
        #2;
        check("rst_reqack", reqack, 1'b0);
        check("rst_respcyc", respcyc, 1'b0);
        check("rst_resp", resp, 64'h0);
        check("rst_resptag", 64'(resptag), 64'h0);
        repeat (3) @(negedge clk);
        reqcyc = 1'b0;
        reset  = 1'b0;

        // write line 0x40, read it back with full-rate and stalled acks
        write_line(64'h40, {1'b0, 4'h1, 8'h05}, 64'h1000, 8);
        issue_read(64'h40, {1'b1, 4'h1, 8'h09});
        collect_burst(1'b0, 1'b0);
        issue_read(64'h40, {1'b1, 4'h1, 8'h09});
        collect_burst(1'b1, 1'b0);

        // unaligned and wrapped addresses hit the same line
        issue_read(64'h47, {1'b1, 4'h1, 8'h0A});
        collect_burst(1'b0, 1'b0);
        issue_read(64'h40 + 64'(MEMW * 8), {1'b1, 4'h1, 8'h0B});
        collect_burst(1'b0, 1'b0);

        // MMIO: zero reads, discarded writes
        write_line(64'h80, {1'b0, 4'h1, 8'h05}, 64'h2000, 8);
        issue_read(64'h80, {1'b1, 4'h2, 8'h03});
        collect_burst(1'b0, 1'b0);
        write_line(64'h80, {1'b0, 4'h2, 8'h03}, 64'hDEAD_0000_0000_0000, 8);
        issue_read(64'h80, {1'b1, 4'h1, 8'h04});
        collect_burst(1'b0, 1'b0);

        // request offered throughout a read is held off until the burst ends
        issue_read(64'h40, {1'b1, 4'h1, 8'h11});
        req = 64'h80; reqtag = {1'b1, 4'h1, 8'h12}; reqcyc = 1'b1;
        collect_burst(1'b0, 1'b1);
        push_expected(64'h80, {1'b1, 4'h1, 8'h12});
        @(negedge clk);
        reqcyc = 1'b0;
        collect_burst(1'b1, 1'b0);

        // reset in the middle of a write keeps the beats already written
        write_line(64'h40, {1'b0, 4'h1, 8'h06}, 64'h3000, 4);
        @(negedge clk);
        req   = 64'h3004;
        reset = 1'b1;
        #1;
        check("midrst_reqack", reqack, 1'b0);
        check("midrst_respcyc", respcyc, 1'b0);
        check("midrst_resp", resp, 64'h0);
        check("midrst_resptag", 64'(resptag), 64'h0);
        @(negedge clk);
        reset  = 1'b0;
        reqcyc = 1'b0;
        issue_read(64'h40, {1'b1, 4'h1, 8'h13});
        collect_burst(1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
